// File: rtl/calc_sched.sv
// calc_sched: pops 3-word packets (header, operand A, operand B) from an input FIFO,
// executes the header opcode and pushes the result word to an output FIFO.
module calc_sched #(
    parameter int RAH_PACKET_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RAH_PACKET_WIDTH-1:0] rd_data,
    input  logic                        empty,
    output logic                        rden,
    output logic [RAH_PACKET_WIDTH-1:0] wr_data,
    input  logic                        full,
    output logic                        wren,
    output logic                        busy,
    output logic [15:0]                 op_count,
    output logic [7:0]                  err_count
);
    localparam int W = RAH_PACKET_WIDTH;
    localparam int H = W / 2;
    localparam logic [W-1:0] W_LIM = W'(W);

    typedef enum logic [3:0] {
        IDLE, CAP_H, POP_A, CAP_A, POP_B, CAP_B, EXEC, MUL2, WRITE
    } state_t;

    state_t       state_q;
    logic [3:0]   hdr_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] res_q;
    logic [W-1:0] wr_last_q;
    logic         busy_q;
    logic [15:0]  op_cnt_q;
    logic [7:0]   err_cnt_q;
    logic [W-1:0] alu_d;
    logic [W-1:0] mul_lo_d;
    logic [W-1:0] mul_hi_d;
    logic         pop_d;
    logic         push_d;

    // Strobes follow this cycle's empty/full so a pop or push never hits a blocked FIFO;
    // rst masks both so a reset cycle can neither pop nor push.
    assign pop_d  = !rst && !empty && (state_q == IDLE || state_q == POP_A || state_q == POP_B);
    assign push_d = !rst && !full && (state_q == WRITE);

    // Multiply split over two cycles: A * B_low in EXEC, then (A * B_high) << H added in MUL2.
    assign mul_lo_d = a_q * {{(W-H){1'b0}}, b_q[H-1:0]};
    assign mul_hi_d = (a_q * {{H{1'b0}}, b_q[W-1:H]}) << H;

    always_comb begin
        alu_d = '0;
        case (hdr_q)
            4'd0:    alu_d = a_q + b_q;
            4'd1:    alu_d = a_q - b_q;
            4'd2:    alu_d = (b_q >= W_LIM) ? '0 : (a_q << b_q);
            4'd3:    alu_d = (b_q >= W_LIM) ? '0 : (a_q >> b_q);
            4'd4:    alu_d = a_q & b_q;
            4'd5:    alu_d = a_q | b_q;
            4'd6:    alu_d = a_q ^ b_q;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            wr_last_q <= '0;
            busy_q    <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= CAP_H;
                        busy_q  <= 1'b1;
                    end
                end
                CAP_H: begin
                    hdr_q   <= rd_data[3:0];
                    state_q <= POP_A;
                end
                POP_A: begin
                    if (!empty) state_q <= CAP_A;
                end
                CAP_A: begin
                    a_q     <= rd_data;
                    state_q <= POP_B;
                end
                POP_B: begin
                    if (!empty) state_q <= CAP_B;
                end
                CAP_B: begin
                    b_q     <= rd_data;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (hdr_q < 4'd7) begin
                        res_q   <= alu_d;
                        state_q <= WRITE;
                    end else if (hdr_q == 4'd7) begin
                        res_q   <= mul_lo_d;
                        state_q <= MUL2;
                    end else begin
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                MUL2: begin
                    res_q   <= res_q + mul_hi_d;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (!full) begin
                        wr_last_q <= res_q;
                        op_cnt_q  <= op_cnt_q + 16'd1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rden      = pop_d;
    assign wren      = push_d;
    assign wr_data   = push_d ? res_q : wr_last_q;
    assign busy      = busy_q;
    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_calc_sched.sv
// Self-checking bench for calc_sched: emulates both FIFOs and compares every push
// against a plain-arithmetic model of the opcode set.
module tb_calc_sched;
    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          empty;
    logic          full;
    logic          rden;
    logic          wren;
    logic          busy;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  wr_data;
    logic [15:0]   op_count;
    logic [7:0]    err_count;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  inq[$];
    int            cyc = 0;
    int            first_rd = -1;
    int            wr_cyc = -1;
    int            n_wren = 0;
    logic [W-1:0]  last_wd = '0;
    logic [W-1:0]  wd_exp = '0;
    logic [15:0]   opc_exp = '0;
    logic [7:0]    err_exp = '0;

    calc_sched #(.RAH_PACKET_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_data   (rd_data),
        .empty     (empty),
        .rden      (rden),
        .wr_data   (wr_data),
        .full      (full),
        .wren      (wren),
        .busy      (busy),
        .op_count  (op_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return (b >= 48'd48) ? '0 : (a << b);
            4'd3:    return (b >= 48'd48) ? '0 : (a >> b);
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return prod[W-1:0];
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [W-1:0] hdr(input logic [3:0] op);
        logic [W-1:0] h;
        h = rand48();
        h[3:0] = op;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        inq.push_back(w);
        empty = 1'b0;
    endtask

    // One clock: sample outputs just after the falling edge, then model the FIFO pop.
    task automatic cycle();
        logic popped;
        #1;
        chk("rden_wren_excl", 64'(rden & wren), 64'(0));
        chk("rden_when_empty", 64'(rden & empty), 64'(0));
        if (!wren && !rst) chk("wr_data_hold", 64'(wr_data), 64'(wd_exp));
        if (rden && first_rd < 0) first_rd = cyc;
        if (wren) begin
            n_wren++;
            wr_cyc  = cyc;
            last_wd = wr_data;
        end
        popped = rden;
        @(negedge clk);
        cyc++;
        if (popped && inq.size() > 0) rd_data = inq.pop_front();
        empty = (inq.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        wd_exp  = '0;
        opc_exp = '0;
        err_exp = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        #1;
        chk({tag, "_rden"}, 64'(rden), 64'(0));
        chk({tag, "_wren"}, 64'(wren), 64'(0));
        chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_opcnt"}, 64'(op_count), 64'(0));
        chk({tag, "_errcnt"}, 64'(err_count), 64'(0));
    endtask

    task automatic wait_write(input string tag, input int n0, input logic [W-1:0] exp);
        int budget;
        budget = 0;
        while (n_wren == n0 && budget < 40) begin
            cycle();
            budget++;
        end
        chk({tag, "_seen"}, 64'(n_wren - n0), 64'(1));
        chk({tag, "_data"}, 64'(last_wd), 64'(exp));
        opc_exp = opc_exp + 16'd1;
        wd_exp  = exp;
        cycle();
        cycle();
        chk({tag, "_once"}, 64'(n_wren - n0), 64'(1));
        chk({tag, "_opcnt"}, 64'(op_count), 64'(opc_exp));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic run_pkt(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit check_lat);
        int n0;
        n0 = n_wren;
        first_rd = -1;
        push(hdr(op));
        push(a);
        push(b);
        if (op >= 4'd8) begin
            repeat (12) cycle();
            if (err_exp != 8'd255) err_exp = err_exp + 8'd1;
            chk({tag, "_nowr"}, 64'(n_wren - n0), 64'(0));
            chk({tag, "_err"}, 64'(err_count), 64'(err_exp));
            chk({tag, "_opcnt"}, 64'(op_count), 64'(opc_exp));
            chk({tag, "_idle"}, 64'(busy), 64'(0));
        end else begin
            wait_write(tag, n0, ref_res(op, a, b));
            if (check_lat)
                chk({tag, "_lat"}, 64'(wr_cyc - first_rd), (op == 4'd7) ? 64'(8) : 64'(7));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst     = 1'b1;
        full    = 1'b0;
        empty   = 1'b1;
        rd_data = '0;
        @(negedge clk);
        do_reset();
        check_zero("reset");

        run_pkt("add", 4'd0, 48'd5, 48'd7, 1'b1);
        run_pkt("shl47", 4'd2, 48'd1, 48'd47, 1'b1);
        run_pkt("shl48", 4'd2, 48'd1, 48'd48, 1'b1);
        run_pkt("sub_wrap", 4'd1, 48'd0, 48'd1, 1'b1);
        run_pkt("shr_big", 4'd3, 48'hFFFF_FFFF_FFFF, 48'h1_0000_0000, 1'b1);
        run_pkt("mul_trunc", 4'd7, 48'h100_0000, 48'h100_0000, 1'b1);
        run_pkt("mul_small", 4'd7, 48'd3, 48'd4, 1'b1);

        // Operand B arrives only after the FIFO has been empty for 5 cycles in POP_B.
        n0 = n_wren;
        push(hdr(4'd0));
        push(48'd100);
        repeat (4) cycle();
        repeat (5) cycle();
        chk("stallB_busy", 64'(busy), 64'(1));
        chk("stallB_nowr", 64'(n_wren - n0), 64'(0));
        push(48'd23);
        wait_write("stallB", n0, 48'd123);

        // Output FIFO full while the result waits in WRITE.
        n0 = n_wren;
        full = 1'b1;
        push(hdr(4'd6));
        push(48'hF0F0_1234_5678);
        push(48'h0FF0_FFFF_0000);
        repeat (18) cycle();
        chk("stallF_nowr", 64'(n_wren - n0), 64'(0));
        chk("stallF_busy", 64'(busy), 64'(1));
        full = 1'b0;
        wait_write("stallF", n0, 48'hF0F0_1234_5678 ^ 48'h0FF0_FFFF_0000);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 4'($urandom_range(0, 9));
            a  = rand48();
            b  = rand48();
            if (op == 4'd2 || op == 4'd3) b = 48'($urandom_range(0, 52));
            if (op == 4'd7 && i[0]) begin
                a = 48'($urandom);
                b = 48'($urandom_range(0, 65535));
            end
            run_pkt($sformatf("rnd%0d", i), op, a, b, 1'b1);
        end

        do_reset();
        n0 = n_wren;
        for (int i = 0; i < 256; i++) run_pkt($sformatf("ill%0d", i), 4'hF, rand48(), rand48(), 1'b0);
        chk("sat_err", 64'(err_count), 64'(255));
        chk("sat_nowr", 64'(n_wren - n0), 64'(0));
        chk("sat_opcnt", 64'(op_count), 64'(0));

        // Reset while a result is ready and full has just dropped: no push may escape.
        n0 = n_wren;
        full = 1'b1;
        push(hdr(4'd0));
        push(48'd1);
        push(48'd1);
        repeat (12) cycle();
        full = 1'b0;
        rst  = 1'b1;
        #1;
        chk("rstW_wren", 64'(wren), 64'(0));
        cycle();
        wd_exp  = '0;
        opc_exp = '0;
        err_exp = '0;
        rst = 1'b0;
        cycle();
        chk("rstW_nowr", 64'(n_wren - n0), 64'(0));
        chk("rstW_opcnt", 64'(op_count), 64'(0));
        chk("rstW_errcnt", 64'(err_count), 64'(0));
        chk("rstW_busy", 64'(busy), 64'(0));

        // Reset while waiting in POP_B: the next word must be taken as a header.
        push(hdr(4'd0));
        push(48'd77);
        repeat (4) cycle();
        chk("rstB_busy", 64'(busy), 64'(1));
        do_reset();
        check_zero("rstB");
        run_pkt("post_rst", 4'd0, 48'd9, 48'd3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
